// File: rtl/noc_rx_endpoint_pkg.sv
// Shared defaults and sizing helpers for the noc_if receive endpoint.
// Imported by the endpoint top and its per-VC FIFO.
package noc_rx_endpoint_pkg;

  localparam int DEFAULT_D_W           = 32;
  localparam int DEFAULT_A_W           = 4;
  localparam int DEFAULT_VC_W          = 2;
  localparam int DEFAULT_VC_FIFO_DEPTH = 4;

  // Index width for a count of n things; a single thing still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a stored flit: payload, last flag and route address.
  function automatic int flit_w(input int d_w, input int a_w);
    return d_w + 1 + a_w;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-clock FIFO holding DEPTH-1 flits of one virtual channel.
// A pop on the same edge frees a slot, so a push to a full FIFO still lands.
module noc_vc_fifo
  import noc_rx_endpoint_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int ENTRIES = DEPTH - 1;
  localparam int PW      = idx_w(ENTRIES);
  localparam int CW      = $clog2(ENTRIES + 1);

  logic [W-1:0]  mem [ENTRIES];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(ENTRIES - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(ENTRIES));
  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noc_rx_endpoint.sv
// Receive endpoint of the credit-based noc_if link: per-VC buffering, credit
// return, packet-atomic round-robin merge onto one valid/ready stream.
module noc_rx_endpoint
  import noc_rx_endpoint_pkg::*;
#(
  parameter int N             = 2,
  parameter int D_W           = DEFAULT_D_W,
  parameter int A_W           = DEFAULT_A_W,
  parameter int VC_W          = DEFAULT_VC_W,
  parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
  parameter int MY_ADDR       = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [VC_W-1:0]        in_vc_target,
  input  logic [D_W-1:0]         in_data,
  input  logic                   in_last,
  input  logic [A_W-1:0]         in_addr,
  output logic [VC_W-1:0]        in_vc_credit_gnt,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [D_W-1:0]         out_data,
  output logic                   out_last,
  output logic [idx_w(VC_W)-1:0] out_vc,
  output logic [31:0]            flit_count,
  output logic [31:0]            pkt_count,
  output logic                   err_overflow,
  output logic                   err_onehot,
  output logic                   err_addr
);

  localparam int VI_W = idx_w(VC_W);
  localparam int F_W  = flit_w(D_W, A_W);

  if (MY_ADDR < 0 || MY_ADDR >= N) begin : g_bad_addr
    $error("noc_rx_endpoint: MY_ADDR outside the client address range");
  end

  typedef struct packed {
    logic [D_W-1:0] data;
    logic           last;
    logic [A_W-1:0] addr;
  } flit_t;

  flit_t            in_flit;
  flit_t            head [VC_W];
  logic             multi_hot;
  logic [VC_W-1:0]  push, pop, full, empty, wr_ok;
  logic             ovf_hit;

  logic [VI_W-1:0]  rr_ptr;
  logic             locked;
  logic             sel_valid;
  logic [VI_W-1:0]  sel;
  logic [VI_W-1:0]  cand;
  logic             load;

  assign in_flit   = '{data: in_data, last: in_last, addr: in_addr};
  assign multi_hot = |(in_vc_target & (in_vc_target - VC_W'(1)));
  assign push      = multi_hot ? '0 : in_vc_target;
  assign wr_ok     = push & (~full | pop);
  assign ovf_hit   = |(push & full & ~pop);

  for (genvar v = 0; v < VC_W; v++) begin : g_vc
    noc_vc_fifo #(.W(F_W), .DEPTH(VC_FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[v]),
      .push_data (in_flit),
      .pop       (pop[v]),
      .pop_data  (head[v]),
      .full      (full[v]),
      .empty     (empty[v])
    );
  end

  // While a packet is open the arbiter is pinned to rr_ptr; otherwise it
  // scans from rr_ptr+1 and wraps, so rr_ptr itself is checked last.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel       = rr_ptr;
    cand      = rr_ptr;
    if (locked) begin
      sel_valid = !empty[rr_ptr];
    end else begin
      for (int i = 1; i <= VC_W; i++) begin
        cand = VI_W'((int'(rr_ptr) + i) % VC_W);
        if (!sel_valid && !empty[cand]) begin
          sel_valid = 1'b1;
          sel       = cand;
        end
      end
    end
  end

  assign load = sel_valid && (!out_valid || out_ready);
  assign pop  = load ? (VC_W'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid        <= 1'b0;
      out_data         <= '0;
      out_last         <= 1'b0;
      out_vc           <= '0;
      rr_ptr           <= '0;
      locked           <= 1'b0;
      in_vc_credit_gnt <= '0;
    end else begin
      in_vc_credit_gnt <= pop;
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= head[sel].data;
        out_last  <= head[sel].last;
        out_vc    <= sel;
        rr_ptr    <= sel;
        locked    <= !head[sel].last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_count   <= '0;
      pkt_count    <= '0;
      err_overflow <= 1'b0;
      err_onehot   <= 1'b0;
      err_addr     <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        flit_count <= flit_count + 32'd1;
        if (out_last) pkt_count <= pkt_count + 32'd1;
      end
      if (multi_hot) err_onehot   <= 1'b1;
      if (ovf_hit)   err_overflow <= 1'b1;
      if (|wr_ok && (in_addr != A_W'(MY_ADDR))) err_addr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_rx_endpoint.sv
// Self-checking bench for noc_rx_endpoint: vector table, directed corner
// sequences and a credit-respecting random soak against per-VC scoreboards.
module tb_noc_rx_endpoint;

  localparam int D_W     = 8;
  localparam int A_W     = 4;
  localparam int VC_W    = 2;
  localparam int DEPTH   = 4;
  localparam int MY_ADDR = 0;
  localparam int VI_W    = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [VC_W-1:0]   in_vc_target;
  logic [D_W-1:0]    in_data;
  logic              in_last;
  logic [A_W-1:0]    in_addr;
  logic [VC_W-1:0]   in_vc_credit_gnt;
  logic              out_valid;
  logic              out_ready;
  logic [D_W-1:0]    out_data;
  logic              out_last;
  logic [VI_W-1:0]   out_vc;
  logic [31:0]       flit_count;
  logic [31:0]       pkt_count;
  logic              err_overflow;
  logic              err_onehot;
  logic              err_addr;

  noc_rx_endpoint #(
    .N(2), .D_W(D_W), .A_W(A_W), .VC_W(VC_W),
    .VC_FIFO_DEPTH(DEPTH), .MY_ADDR(MY_ADDR)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_vc_target     (in_vc_target),
    .in_data          (in_data),
    .in_last          (in_last),
    .in_addr          (in_addr),
    .in_vc_credit_gnt (in_vc_credit_gnt),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_last         (out_last),
    .out_vc           (out_vc),
    .flit_count       (flit_count),
    .pkt_count        (pkt_count),
    .err_overflow     (err_overflow),
    .err_onehot       (err_onehot),
    .err_addr         (err_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [D_W:0]          exp_q [VC_W][$];
  logic [VI_W+D_W-1:0]   out_log[$];
  int                    credit_cnt [VC_W];
  int                    sent_ok    [VC_W];
  int                    cred       [VC_W];
  int                    credit_multi;

  typedef struct {
    logic [VC_W-1:0] tgt;
    logic [D_W-1:0]  data;
    logic            last;
    logic [A_W-1:0]  addr;
    bit              store;
    logic            e_onehot;
    logic            e_addr;
    logic            e_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int v = 0; v < VC_W; v++) s += exp_q[v].size();
    return s;
  endfunction

  // Scoreboard and credit monitor, sampled on the falling edge.
  logic [D_W:0] mon_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(in_vc_credit_gnt) > 1) credit_multi++;
      for (int v = 0; v < VC_W; v++) begin
        if (in_vc_credit_gnt[v]) begin
          credit_cnt[v]++;
          cred[v]++;
        end
      end
      if (out_valid && out_ready) begin
        out_log.push_back({out_vc, out_data});
        if (exp_q[out_vc].size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_flit: got vc %0d data %0h expected none", out_vc, out_data);
        end else begin
          mon_exp = exp_q[out_vc].pop_front();
          check("scoreboard_flit", {out_data, out_last}, mon_exp);
        end
      end
    end
  end

  task automatic send(input logic [VC_W-1:0] tgt, input logic [D_W-1:0] d,
                      input logic l, input logic [A_W-1:0] a, input bit store);
    in_vc_target = tgt;
    in_data      = d;
    in_last      = l;
    in_addr      = a;
    if (store) begin
      for (int v = 0; v < VC_W; v++) begin
        if (tgt[v]) begin
          exp_q[v].push_back({d, l});
          sent_ok[v]++;
        end
      end
    end
    @(posedge clk);
    #1;
    in_vc_target = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    in_vc_target = '0;
    in_data      = '0;
    in_last      = 1'b0;
    in_addr      = '0;
    credit_multi = 0;
    out_log.delete();
    for (int v = 0; v < VC_W; v++) begin
      exp_q[v].delete();
      credit_cnt[v] = 0;
      sent_ok[v]    = 0;
      cred[v]       = DEPTH - 1;
    end
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((out_valid || pending() != 0) && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({name, "_drain_in_time"}, (c < budget), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int exp_flits, exp_pkts, sent, cyc, v, any_open;
    bit l;
    bit open_pkt [VC_W];

    out_ready = 1'b1;
    do_reset();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_credit", in_vc_credit_gnt, 0);
    check("rst_out_data", {out_data, out_last, out_vc}, 0);
    check("rst_counts", {flit_count, pkt_count}, 0);
    check("rst_errs", {err_overflow, err_onehot, err_addr}, 0);

    // Single flit latency
    send(2'b01, 8'hA5, 1'b1, A_W'(MY_ADDR), 1'b1);
    check("lat_not_yet", out_valid, 0);
    idle(1);
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 8'hA5);
    check("lat_vc", out_vc, 0);
    check("lat_credit", in_vc_credit_gnt, 2'b01);
    idle(1);
    check("lat_credit_gone", in_vc_credit_gnt, 0);
    check("lat_flit_count", flit_count, 1);
    check("lat_pkt_count", pkt_count, 1);

    // Vector table: flag behaviour and storage of each flit
    vecs[0] = '{2'b01, 8'hA5, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{2'b10, 8'h3C, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{2'b01, 8'h11, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{2'b01, 8'h22, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 8'hFF, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{2'b10, 8'h77, 1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{2'b00, 8'h00, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[7] = '{2'b10, 8'h5A, 1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    exp_flits = 0;
    exp_pkts  = 0;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].tgt, vecs[i].data, vecs[i].last, vecs[i].addr, vecs[i].store);
      if (vecs[i].store) begin
        exp_flits++;
        if (vecs[i].last) exp_pkts++;
      end
      idle(3);
      check($sformatf("vec%0d_err_onehot", i), err_onehot, vecs[i].e_onehot);
      check($sformatf("vec%0d_err_addr", i), err_addr, vecs[i].e_addr);
      check($sformatf("vec%0d_err_overflow", i), err_overflow, vecs[i].e_ovf);
    end
    wait_drain("vec", 100);
    check("vec_flit_count", flit_count, exp_flits);
    check("vec_pkt_count", pkt_count, exp_pkts);

    // Backpressure, full-FIFO push with same-edge pop, then true overflow
    out_ready = 1'b0;
    do_reset();
    send(2'b10, 8'h10, 1'b1, 4'd0, 1'b1);
    send(2'b10, 8'h11, 1'b1, 4'd0, 1'b1);
    send(2'b10, 8'h12, 1'b1, 4'd0, 1'b1);
    idle(3);
    check("bp_one_credit", credit_cnt[1], 1);
    check("bp_no_ovf", err_overflow, 0);
    send(2'b10, 8'h13, 1'b1, 4'd0, 1'b1);
    idle(2);
    check("bp_full_no_ovf", err_overflow, 0);
    out_ready = 1'b1;
    send(2'b10, 8'h14, 1'b1, 4'd0, 1'b1);
    out_ready = 1'b0;
    check("bp_pop_push_no_ovf", err_overflow, 0);
    idle(1);
    send(2'b10, 8'h15, 1'b1, 4'd0, 1'b0);
    check("bp_ovf", err_overflow, 1);
    out_ready = 1'b1;
    wait_drain("bp", 100);
    check("bp_flit_count", flit_count, 5);
    check("bp_credits", credit_cnt[1], 5);

    // Interleaved packets on two VCs come out packet-contiguous
    do_reset();
    send(2'b01, 8'hA0, 1'b0, 4'd0, 1'b1);
    send(2'b10, 8'hB0, 1'b0, 4'd0, 1'b1);
    send(2'b01, 8'hA1, 1'b0, 4'd0, 1'b1);
    send(2'b10, 8'hB1, 1'b1, 4'd0, 1'b1);
    send(2'b01, 8'hA2, 1'b1, 4'd0, 1'b1);
    wait_drain("il", 100);
    check("il_len", out_log.size(), 5);
    if (out_log.size() == 5) begin
      check("il_0", out_log[0], {1'b0, 8'hA0});
      check("il_1", out_log[1], {1'b0, 8'hA1});
      check("il_2", out_log[2], {1'b0, 8'hA2});
      check("il_3", out_log[3], {1'b1, 8'hB0});
      check("il_4", out_log[4], {1'b1, 8'hB1});
    end
    check("il_pkt_count", pkt_count, 2);
    check("il_flit_count", flit_count, 5);

    // Reset in the middle of a packet
    do_reset();
    send(2'b01, 8'hC0, 1'b0, 4'd0, 1'b1);
    send(2'b01, 8'hC1, 1'b0, 4'd0, 1'b1);
    check("mid_valid_before", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_valid", out_valid, 0);
    check("mid_counts", {flit_count, pkt_count}, 0);
    check("mid_credit", in_vc_credit_gnt, 0);
    do_reset();
    send(2'b10, 8'hD0, 1'b0, 4'd0, 1'b1);
    send(2'b10, 8'hD1, 1'b1, 4'd0, 1'b1);
    wait_drain("mid", 100);
    check("mid_flit_count", flit_count, 2);
    check("mid_pkt_count", pkt_count, 1);
    check("mid_credits_vc0", credit_cnt[0], 0);
    check("mid_credits_vc1", credit_cnt[1], 2);

    // Random soak; the sender starts from one credit per storage entry
    do_reset();
    sent = 0;
    cyc  = 0;
    for (int i = 0; i < VC_W; i++) open_pkt[i] = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(99) < 90);
      cyc++;
      v = $urandom_range(VC_W - 1);
      if ($urandom_range(99) < 30 && cred[v] > 0) begin
        cred[v]--;
        l = ($urandom_range(3) == 0);
        send(VC_W'(1) << v, D_W'($urandom), l, A_W'(MY_ADDR), 1'b1);
        open_pkt[v] = !l;
        sent++;
      end else begin
        idle(1);
      end
    end
    check("soak_sent_all", (sent >= 1000), 1);
    out_ready = 1'b1;
    any_open  = 1;
    while (any_open != 0 && cyc < 25000) begin
      any_open = 0;
      cyc++;
      for (int i = 0; i < VC_W; i++) if (open_pkt[i]) any_open = 1;
      v = -1;
      for (int i = 0; i < VC_W; i++) if (v < 0 && open_pkt[i] && cred[i] > 0) v = i;
      if (v >= 0) begin
        cred[v]--;
        send(VC_W'(1) << v, D_W'($urandom), 1'b1, A_W'(MY_ADDR), 1'b1);
        open_pkt[v] = 1'b0;
      end else if (any_open != 0) begin
        idle(1);
      end
    end
    check("soak_packets_closed", any_open, 0);
    wait_drain("soak", 2000);
    check("soak_errs", {err_overflow, err_onehot, err_addr}, 0);
    check("soak_credits_vc0", credit_cnt[0], sent_ok[0]);
    check("soak_credits_vc1", credit_cnt[1], sent_ok[1]);
    check("soak_flit_count", flit_count, sent_ok[0] + sent_ok[1]);
    check("soak_credit_onehot", credit_multi, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
